mem_port_arbiter: RTL and testbench

Shares the single PDP-8 memory port between the instruction fetch/decode unit (IFD) read port and the execution unit's read and write ports. It sits between the IFD/exec units and the memory model. It serializes one transaction at a time through a small FSM, using fixed exec-first priority with an aging guard so IFD fetches cannot starve. It also applies a response timeout so a silent memory cannot hang the pipeline.

---
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for the PDP-8 core: serializes IFD reads and exec
// reads/writes onto one memory port, exec-first with an IFD aging guard and a WAIT timeout.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12,
  parameter int MAX_WAIT   = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ifd_rd_req,
  input  logic [ADDR_WIDTH-1:0] ifd_rd_addr,
  output logic [DATA_WIDTH-1:0] ifd_rd_data,
  output logic                  ifd_rd_valid,
  input  logic                  exec_rd_req,
  input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
  output logic [DATA_WIDTH-1:0] exec_rd_data,
  output logic                  exec_rd_valid,
  input  logic                  exec_wr_req,
  input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
  input  logic [DATA_WIDTH-1:0] exec_wr_data,
  output logic                  exec_wr_ack,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_done,
  output logic                  timeout_err
);

  localparam int AGW = $clog2(MAX_WAIT + 1);
  localparam int TMW = $clog2(TIMEOUT);
  localparam logic [AGW-1:0] AGE_MAX  = AGW'(MAX_WAIT);
  localparam logic [TMW-1:0] TMO_LAST = TMW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  typedef enum logic [1:0] {G_IFD, G_ERD, G_EWR} gnt_t;

  state_t                state_q, state_d;
  gnt_t                  gnt_q, gnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic [AGW-1:0]        age_q, age_d;
  logic [TMW-1:0]        tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0] ifd_data_q, ifd_data_d;
  logic [DATA_WIDTH-1:0] erd_data_q, erd_data_d;
  logic                  terr_q, terr_d;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    age_d      = age_q;
    tmo_d      = tmo_q;
    ifd_data_d = ifd_data_q;
    erd_data_d = erd_data_q;
    terr_d     = terr_q;
    case (state_q)
      S_IDLE: begin
        if (!ifd_rd_req) age_d = '0;
        if (ifd_rd_req || exec_rd_req || exec_wr_req) begin
          state_d = S_ISSUE;
          // IFD wins when it has aged out, or when no exec port is asking.
          if (ifd_rd_req && (age_q == AGE_MAX || !(exec_wr_req || exec_rd_req))) begin
            gnt_d  = G_IFD;
            addr_d = ifd_rd_addr;
            we_d   = 1'b0;
            age_d  = '0;
          end else begin
            if (exec_wr_req) begin
              gnt_d   = G_EWR;
              addr_d  = exec_wr_addr;
              wdata_d = exec_wr_data;
              we_d    = 1'b1;
            end else begin
              gnt_d  = G_ERD;
              addr_d = exec_rd_addr;
              we_d   = 1'b0;
            end
            if (ifd_rd_req) age_d = age_q + 1'b1;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        tmo_d   = '0;
      end
      S_WAIT: begin
        if (mem_done) begin
          state_d = S_RESP;
          if (gnt_q == G_IFD) ifd_data_d = mem_rdata;
          if (gnt_q == G_ERD) erd_data_d = mem_rdata;
        end else if (tmo_q == TMO_LAST) begin
          // Abort: requester still completes, with zeroed read data.
          state_d = S_RESP;
          terr_d  = 1'b1;
          if (gnt_q == G_IFD) ifd_data_d = '0;
          if (gnt_q == G_ERD) erd_data_d = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      gnt_q      <= G_IFD;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      age_q      <= '0;
      tmo_q      <= '0;
      ifd_data_q <= '0;
      erd_data_q <= '0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      age_q      <= age_d;
      tmo_q      <= tmo_d;
      ifd_data_q <= ifd_data_d;
      erd_data_q <= erd_data_d;
      terr_q     <= terr_d;
    end
  end

  assign mem_req       = (state_q == S_ISSUE);
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign ifd_rd_valid  = (state_q == S_RESP) && (gnt_q == G_IFD);
  assign exec_rd_valid = (state_q == S_RESP) && (gnt_q == G_ERD);
  assign exec_wr_ack   = (state_q == S_RESP) && (gnt_q == G_EWR);
  assign ifd_rd_data   = ifd_data_q;
  assign exec_rd_data  = erd_data_q;
  assign timeout_err   = terr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed + randomized bench for mem_port_arbiter: memory responder with
// configurable delay, scoreboard of grant order and returned data.
module tb_mem_port_arbiter;
  localparam int AW = 12, DW = 12, MW = 4, TO = 64;

  logic          clk = 1'b0, reset_n;
  logic          ifd_rd_req, exec_rd_req, exec_wr_req;
  logic [AW-1:0] ifd_rd_addr, exec_rd_addr, exec_wr_addr;
  logic [DW-1:0] exec_wr_data;
  logic [DW-1:0] ifd_rd_data, exec_rd_data;
  logic          ifd_rd_valid, exec_rd_valid, exec_wr_ack;
  logic          mem_req, mem_we, mem_done, timeout_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .ifd_rd_req(ifd_rd_req), .ifd_rd_addr(ifd_rd_addr), .ifd_rd_data(ifd_rd_data),
    .ifd_rd_valid(ifd_rd_valid),
    .exec_rd_req(exec_rd_req), .exec_rd_addr(exec_rd_addr), .exec_rd_data(exec_rd_data),
    .exec_rd_valid(exec_rd_valid),
    .exec_wr_req(exec_wr_req), .exec_wr_addr(exec_wr_addr), .exec_wr_data(exec_wr_data),
    .exec_wr_ack(exec_wr_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: mem_done arrives mem_d cycles after the mem_req cycle.
  logic [DW-1:0] mem     [4096];
  logic [DW-1:0] ref_mem [4096];
  int            mem_d = 1;
  bit            silent = 1'b0;
  int            mcnt = 0;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;

  initial begin
    mem_done = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_done = 1'b0;
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          mem_done = 1'b1;
          if (m_we) mem[m_addr] = m_wdata;
          else      mem_rdata = mem[m_addr];
        end
      end
      if (mem_req && !silent) begin
        m_addr = mem_addr; m_we = mem_we; m_wdata = mem_wdata; mcnt = mem_d;
      end
    end
  end

  int n_err = 0, n_chk = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; int c;} iss_t;
  typedef struct {int port; logic [DW-1:0] data; int c;} cmp_t;   // 0 ifd, 1 erd, 2 ewr
  typedef struct {int port; logic [AW-1:0] addr; logic [DW-1:0] wdata;} exp_t;
  iss_t iss_q[$];
  cmp_t cmp_q[$];
  exp_t exp_q[$];
  int   ifd_more = 0, erd_more = 0;

  // Step cycles, log strobes and completions, and retire requests on their pulse.
  task automatic run(input int n, input int budget);
    int   k;
    iss_t is;
    cmp_t cm;
    k = 0;
    iss_q.delete(); cmp_q.delete();
    while (cmp_q.size() < n && k < budget) begin
      @(posedge clk); #1; k++;
      if (mem_req) begin
        is.we = mem_we; is.addr = mem_addr; is.wdata = mem_wdata; is.c = cyc;
        iss_q.push_back(is);
      end
      if (ifd_rd_valid) begin
        cm.port = 0; cm.data = ifd_rd_data; cm.c = cyc; cmp_q.push_back(cm);
        if (ifd_more > 0) ifd_more--; else ifd_rd_req = 1'b0;
      end
      if (exec_rd_valid) begin
        cm.port = 1; cm.data = exec_rd_data; cm.c = cyc; cmp_q.push_back(cm);
        if (erd_more > 0) erd_more--; else exec_rd_req = 1'b0;
      end
      if (exec_wr_ack) begin
        cm.port = 2; cm.data = '0; cm.c = cyc; cmp_q.push_back(cm);
        exec_wr_req = 1'b0;
      end
    end
    chk("completions", 64'(cmp_q.size()), 64'(n));
  endtask

  // Reference: expected transactions in grant order; memory contents evolve in that order.
  task automatic check_exp(input string tag);
    exp_t e;
    chk({tag, "_nissue"}, 64'(iss_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < iss_q.size() && i < cmp_q.size(); i++) begin
      e = exp_q[i];
      chk({tag, "_port"}, 64'(cmp_q[i].port), 64'(e.port));
      chk({tag, "_addr"}, 64'(iss_q[i].addr), 64'(e.addr));
      chk({tag, "_we"},   64'(iss_q[i].we), 64'(e.port == 2));
      if (e.port == 2) begin
        chk({tag, "_wdata"}, 64'(iss_q[i].wdata), 64'(e.wdata));
        ref_mem[e.addr] = e.wdata;
      end else begin
        chk({tag, "_rdata"}, 64'(cmp_q[i].data), 64'(ref_mem[e.addr]));
      end
    end
  endtask

  task automatic push_exp(input int port, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    exp_t e;
    e.port = port; e.addr = a; e.wdata = wd;
    exp_q.push_back(e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int            t0, cnt, mask;
    logic [AW-1:0] a_i, a_r, a_w;
    logic [DW-1:0] wd;
    for (int i = 0; i < 4096; i++) begin mem[i] = DW'($urandom); ref_mem[i] = mem[i]; end
    reset_n = 1'b0;
    ifd_rd_req = 0; exec_rd_req = 0; exec_wr_req = 0;
    ifd_rd_addr = '0; exec_rd_addr = '0; exec_wr_addr = '0; exec_wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {mem_req, mem_we, mem_addr, mem_wdata, ifd_rd_valid, ifd_rd_data,
                          exec_rd_valid, exec_rd_data, exec_wr_ack, timeout_err}, 64'd0);
    reset_n = 1'b1;

    // Single IFD read, D=1
    mem[12'o200] = 12'o7402; ref_mem[12'o200] = 12'o7402; mem_d = 1;
    @(posedge clk); #1;
    ifd_rd_addr = 12'o200; ifd_rd_req = 1'b1; t0 = cyc + 1;
    run(1, 20);
    chk("ifd_nissue", 64'(iss_q.size()), 64'd1);
    if (iss_q.size() == 1 && cmp_q.size() == 1) begin
      chk("ifd_issue_cycle", 64'(iss_q[0].c), 64'(t0));
      chk("ifd_addr", 64'(iss_q[0].addr), 64'(12'o200));
      chk("ifd_valid_cycle", 64'(cmp_q[0].c), 64'(t0 + 2));
      chk("ifd_data", 64'(cmp_q[0].data), 64'(12'o7402));
    end
    repeat (3) @(posedge clk);
    #1 chk("ifd_data_held", 64'(ifd_rd_data), 64'(12'o7402));

    // Exec write
    @(posedge clk); #1;
    exec_wr_addr = 12'o050; exec_wr_data = 12'o1234; exec_wr_req = 1'b1;
    exp_q.delete(); push_exp(2, 12'o050, 12'o1234);
    run(1, 20);
    check_exp("wr");
    cnt = 0;
    repeat (4) begin @(posedge clk); #1; if (exec_wr_ack) cnt++; end
    chk("wr_single_ack", 64'(cnt), 64'd0);
    chk("wr_rd_outputs_unchanged", {ifd_rd_data, exec_rd_data}, {12'o7402, 12'o0000});

    // Exec read-back with D=3: latency 2+D
    mem_d = 3;
    @(posedge clk); #1;
    exec_rd_addr = 12'o050; exec_rd_req = 1'b1; t0 = cyc + 1;
    exp_q.delete(); push_exp(1, 12'o050, '0);
    run(1, 30);
    check_exp("rd_d3");
    if (cmp_q.size() == 1) chk("rd_d3_valid_cycle", 64'(cmp_q[0].c), 64'(t0 + 1 + 3));

    // Simultaneous requests
    mem_d = 1;
    a_w = AW'($urandom); a_r = AW'($urandom); a_i = AW'($urandom); wd = DW'($urandom);
    @(posedge clk); #1;
    exec_wr_addr = a_w; exec_wr_data = wd; exec_rd_addr = a_r; ifd_rd_addr = a_i;
    exec_wr_req = 1; exec_rd_req = 1; ifd_rd_req = 1;
    exp_q.delete(); push_exp(2, a_w, wd); push_exp(1, a_r, '0); push_exp(0, a_i, '0);
    run(3, 40);
    check_exp("simul");

    // Starvation guard: exec_rd never drops; IFD served after every MW exec grants
    @(posedge clk); #1;
    a_r = AW'($urandom); a_i = AW'($urandom);
    exec_rd_addr = a_r; ifd_rd_addr = a_i; exec_rd_req = 1; ifd_rd_req = 1;
    erd_more = 2 * MW - 1; ifd_more = 1;
    exp_q.delete();
    for (int g = 0; g < 2; g++) begin
      for (int e = 0; e < MW; e++) push_exp(1, a_r, '0);
      push_exp(0, a_i, '0);
    end
    run(2 * MW + 2, 120);
    check_exp("starve");

    // Randomized rounds of simultaneous subsets over a small address window
    for (int r = 0; r < 12; r++) begin
      mask = $urandom_range(1, 7);
      mem_d = $urandom_range(1, 4);
      a_w = AW'($urandom_range(0, 7)); a_r = AW'($urandom_range(0, 7));
      a_i = AW'($urandom_range(0, 7)); wd = DW'($urandom);
      @(posedge clk); #1;
      exec_wr_addr = a_w; exec_wr_data = wd; exec_rd_addr = a_r; ifd_rd_addr = a_i;
      exec_wr_req = mask[2]; exec_rd_req = mask[1]; ifd_rd_req = mask[0];
      exp_q.delete();
      if (mask[2]) push_exp(2, a_w, wd);
      if (mask[1]) push_exp(1, a_r, '0);
      if (mask[0]) push_exp(0, a_i, '0);
      run(exp_q.size(), 60);
      check_exp("rnd");
    end

    // Timeout with a silent memory
    chk("terr_before_timeout", 64'(timeout_err), 64'd0);
    silent = 1'b1;
    @(posedge clk); #1;
    exec_rd_addr = AW'($urandom); exec_rd_req = 1'b1; t0 = cyc + 1;
    run(1, 100);
    if (cmp_q.size() == 1) begin
      chk("tmo_valid_cycle", 64'(cmp_q[0].c), 64'(t0 + 1 + TO));
      chk("tmo_data_zero", 64'(cmp_q[0].data), 64'd0);
    end
    chk("tmo_err_set", 64'(timeout_err), 64'd1);
    silent = 1'b0; mem_d = 2;
    @(posedge clk); #1;
    a_i = AW'($urandom); ifd_rd_addr = a_i; ifd_rd_req = 1'b1;
    exp_q.delete(); push_exp(0, a_i, '0);
    run(1, 20);
    check_exp("post_tmo");
    chk("tmo_err_sticky", 64'(timeout_err), 64'd1);

    // Asynchronous reset mid-WAIT; the late mem_done must be ignored
    mem_d = 10;
    @(posedge clk); #1;
    exec_rd_addr = AW'($urandom); exec_rd_req = 1'b1;
    repeat (4) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("midwait_reset_outputs", {mem_req, mem_we, mem_addr, mem_wdata, ifd_rd_valid, ifd_rd_data,
                                  exec_rd_valid, exec_rd_data, exec_wr_ack, timeout_err}, 64'd0);
    exec_rd_req = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (ifd_rd_valid || exec_rd_valid || exec_wr_ack || mem_req) cnt++;
    end
    chk("post_reset_quiet", 64'(cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
